// File: rtl/pkt_rr_arb.sv
// Two-input packet-level round-robin arbiter with one registered output stage.
// Optional per-channel packet counters are enabled with `define PKT_RR_ARB_STAT_EN.
module pkt_rr_arb #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    s0_data,
  input  logic             s0_vld,
  input  logic             s0_sop,
  input  logic             s0_eop,
  output logic             s0_rdy,
  input  logic [DW-1:0]    s1_data,
  input  logic             s1_vld,
  input  logic             s1_sop,
  input  logic             s1_eop,
  output logic             s1_rdy,
  output logic [DW-1:0]    m_data,
  output logic             m_vld,
  output logic             m_sop,
  output logic             m_eop,
  input  logic             m_rdy,
  output logic             m_ch,
  output logic [CNT_W-1:0] err_cnt
`ifdef PKT_RR_ARB_STAT_EN
  ,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_gnt_q, last_gnt_d;
  logic               first_q, first_d;
  logic [DW-1:0]      m_data_q, m_data_d;
  logic               m_vld_q, m_vld_d;
  logic               m_sop_q, m_sop_d;
  logic               m_eop_q, m_eop_d;
  logic               m_ch_q, m_ch_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic               ld;
  logic               req0, req1;
  logic               acc0, acc1;
  logic               orphan0, orphan1;
  logic               seq_err;
  logic [1:0]         err_inc;
  logic               s0_rdy_c, s1_rdy_c;

  // Saturating add of a small increment to the error counter.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    if (sum[CNT_W]) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  assign ld   = !m_vld_q || m_rdy;
  assign req0 = s0_vld && s0_sop;
  assign req1 = s1_vld && s1_sop;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state, grant history and first-beat tracking.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    first_d    = first_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          state_d = last_gnt_q ? GNT0 : GNT1;
          first_d = 1'b1;
        end else if (req0) begin
          state_d = GNT0;
          first_d = 1'b1;
        end else if (req1) begin
          state_d = GNT1;
          first_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (acc0) begin
          first_d = 1'b0;
          if (s0_eop) begin
            state_d    = IDLE;
            last_gnt_d = 1'b0;
          end else begin
            state_d = GNT0;
          end
        end else begin
          state_d = GNT0;
        end
      end
      GNT1: begin
        if (acc1) begin
          first_d = 1'b0;
          if (s1_eop) begin
            state_d    = IDLE;
            last_gnt_d = 1'b1;
          end else begin
            state_d = GNT1;
          end
        end else begin
          state_d = GNT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: ready, accept and framing-error strobes.
  always_comb begin
    s0_rdy_c = 1'b0;
    s1_rdy_c = 1'b0;
    orphan0  = 1'b0;
    orphan1  = 1'b0;
    case (state_q)
      IDLE: begin
        // Orphan beats are swallowed so they cannot wedge the channel.
        orphan0  = s0_vld && !s0_sop;
        orphan1  = s1_vld && !s1_sop;
        s0_rdy_c = orphan0;
        s1_rdy_c = orphan1;
      end
      GNT0: begin
        s0_rdy_c = ld;
      end
      GNT1: begin
        s1_rdy_c = ld;
      end
      default: begin
        s0_rdy_c = 1'b0;
        s1_rdy_c = 1'b0;
      end
    endcase
    acc0    = (state_q == GNT0) && s0_vld && ld;
    acc1    = (state_q == GNT1) && s1_vld && ld;
    seq_err = ((acc0 && s0_sop) || (acc1 && s1_sop)) && !first_q;
    err_inc = {1'b0, orphan0} + {1'b0, orphan1} + {1'b0, seq_err};
  end

  assign s0_rdy = s0_rdy_c;
  assign s1_rdy = s1_rdy_c;

  // Output stage and error counter next values.
  always_comb begin
    m_data_d  = m_data_q;
    m_vld_d   = m_vld_q;
    m_sop_d   = m_sop_q;
    m_eop_d   = m_eop_q;
    m_ch_d    = m_ch_q;
    if (acc0) begin
      m_data_d = s0_data;
      m_vld_d  = 1'b1;
      m_sop_d  = s0_sop;
      m_eop_d  = s0_eop;
      m_ch_d   = 1'b0;
    end else if (acc1) begin
      m_data_d = s1_data;
      m_vld_d  = 1'b1;
      m_sop_d  = s1_sop;
      m_eop_d  = s1_eop;
      m_ch_d   = 1'b1;
    end else if (ld) begin
      m_vld_d = 1'b0;
    end else begin
      m_vld_d = m_vld_q;
    end
    err_cnt_d = sat_add(err_cnt_q, err_inc);
  end

  // Control, output and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= 1'b1;
      first_q    <= 1'b0;
      m_data_q   <= {DW{1'b0}};
      m_vld_q    <= 1'b0;
      m_sop_q    <= 1'b0;
      m_eop_q    <= 1'b0;
      m_ch_q     <= 1'b0;
      err_cnt_q  <= {CNT_W{1'b0}};
    end else begin
      last_gnt_q <= last_gnt_d;
      first_q    <= first_d;
      m_data_q   <= m_data_d;
      m_vld_q    <= m_vld_d;
      m_sop_q    <= m_sop_d;
      m_eop_q    <= m_eop_d;
      m_ch_q     <= m_ch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_vld   = m_vld_q;
  assign m_sop   = m_sop_q;
  assign m_eop   = m_eop_q;
  assign m_ch    = m_ch_q;
  assign err_cnt = err_cnt_q;

`ifdef PKT_RR_ARB_STAT_EN
  logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

  // Per-channel completed-packet counters, wrapping.
  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    if (acc0 && s0_eop) begin
      pkt_cnt0_d = pkt_cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pkt_cnt0_d = pkt_cnt0_q;
    end
    if (acc1 && s1_eop) begin
      pkt_cnt1_d = pkt_cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pkt_cnt1_d = pkt_cnt1_q;
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0_q <= {CNT_W{1'b0}};
      pkt_cnt1_q <= {CNT_W{1'b0}};
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Bench for pkt_rr_arb: directed scenarios plus randomized traffic checked
// against a packet-level round-robin model.
module tb_pkt_rr_arb;
  localparam int DW    = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [DW-1:0]    s0_data, s1_data, m_data;
  logic             s0_vld, s0_sop, s0_eop, s0_rdy;
  logic             s1_vld, s1_sop, s1_eop, s1_rdy;
  logic             m_vld, m_sop, m_eop, m_rdy, m_ch;
  logic [CNT_W-1:0] err_cnt;
`ifdef PKT_RR_ARB_STAT_EN
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
`endif

  always #5 clk = ~clk;

  pkt_rr_arb #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_vld(s0_vld), .s0_sop(s0_sop), .s0_eop(s0_eop), .s0_rdy(s0_rdy),
    .s1_data(s1_data), .s1_vld(s1_vld), .s1_sop(s1_sop), .s1_eop(s1_eop), .s1_rdy(s1_rdy),
    .m_data(m_data), .m_vld(m_vld), .m_sop(m_sop), .m_eop(m_eop), .m_rdy(m_rdy),
    .m_ch(m_ch), .err_cnt(err_cnt)
`ifdef PKT_RR_ARB_STAT_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [9:0]  q0[$];
  logic [9:0]  q1[$];
  logic [10:0] expq[$];
  int          ptr0, ptr1, cyc, first_out, last_out;
  bit          m_last;
  int          rdy_mode, stall_lo, stall_hi;
  bit          gap_en;
  bit          hold_prev;
  logic [10:0] held;
  int          pc0, pc1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_beat(input int ch, input bit sop, input bit eop, input logic [7:0] d);
    if (ch == 0) begin
      q0.push_back({sop, eop, d});
      if (eop) pc0++;
    end else begin
      q1.push_back({sop, eop, d});
      if (eop) pc1++;
    end
  endtask

  task automatic add_pkt(input int ch, input int len);
    for (int i = 0; i < len; i++)
      add_beat(ch, i == 0, i == len - 1, 8'($urandom_range(0, 255)));
  endtask

  // Packet-level model: whole packets, alternating when both channels have one waiting.
  task automatic build_exp();
    int i0 = 0;
    int i1 = 0;
    int pick;
    bit done;
    while (i0 < q0.size() || i1 < q1.size()) begin
      if (i0 < q0.size() && i1 < q1.size()) pick = m_last ? 0 : 1;
      else pick = (i0 < q0.size()) ? 0 : 1;
      m_last = (pick == 1);
      done = 1'b0;
      while (!done) begin
        if (pick == 0) begin
          expq.push_back({1'b0, q0[i0]});
          done = q0[i0][8];
          i0++;
        end else begin
          expq.push_back({1'b1, q1[i1]});
          done = q1[i1][8];
          i1++;
        end
      end
    end
  endtask

  task automatic drive();
    if (ptr0 < q0.size()) begin
      {s0_sop, s0_eop, s0_data} = q0[ptr0];
      s0_vld = !(gap_en && !q0[ptr0][9] && $urandom_range(0, 3) == 0);
    end else begin
      {s0_vld, s0_sop, s0_eop, s0_data} = 11'd0;
    end
    if (ptr1 < q1.size()) begin
      {s1_sop, s1_eop, s1_data} = q1[ptr1];
      s1_vld = !(gap_en && !q1[ptr1][9] && $urandom_range(0, 3) == 0);
    end else begin
      {s1_vld, s1_sop, s1_eop, s1_data} = 11'd0;
    end
    case (rdy_mode)
      0: m_rdy = 1'b1;
      1: m_rdy = ($urandom_range(0, 2) != 0);
      default: m_rdy = !(cyc >= stall_lo && cyc <= stall_hi);
    endcase
  endtask

  // One clock: drive at negedge, sample 1ns later, then advance to next negedge.
  task automatic cycle();
    drive();
    #1;
    if (hold_prev) check("hold_stable", 32'({m_ch, m_sop, m_eop, m_data}), 32'(held));
    if (m_vld && m_rdy) begin
      check("out_beat", 32'({m_ch, m_sop, m_eop, m_data}),
            (expq.size() != 0) ? 32'(expq.pop_front()) : 32'hDEAD_BEEF);
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (m_vld && !m_rdy) check("stall_rdy", 32'({s0_rdy, s1_rdy}), 32'd0);
    hold_prev = m_vld && !m_rdy;
    held = {m_ch, m_sop, m_eop, m_data};
    if (s0_vld && s0_rdy) ptr0++;
    if (s1_vld && s1_rdy) ptr1++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_run();
    ptr0 = 0; ptr1 = 0; cyc = 0;
    first_out = -1; last_out = -1; hold_prev = 1'b0;
  endtask

  task automatic run(input int budget);
    start_run();
    while ((ptr0 < q0.size() || ptr1 < q1.size() || expq.size() != 0) && cyc < budget) cycle();
    check("drained", 32'(expq.size() + (q0.size() - ptr0) + (q1.size() - ptr1)), 32'd0);
    q0.delete(); q1.delete(); expq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {s0_vld, s0_sop, s0_eop, s0_data} = 11'd0;
    {s1_vld, s1_sop, s1_eop, s1_data} = 11'd0;
    m_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1; pc0 = 0; pc1 = 0; hold_prev = 1'b0;
    q0.delete(); q1.delete(); expq.delete();
  endtask

  initial begin
    rst_n = 1'b0; rdy_mode = 0; gap_en = 1'b0; stall_lo = 0; stall_hi = -1;
    do_reset();
    #1;
    check("rst_m_out", 32'({m_vld, m_sop, m_eop, m_ch, m_data}), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    @(negedge clk);

    // Single packet on ch0.
    add_beat(0, 1'b1, 1'b0, 8'hAA); add_beat(0, 1'b0, 1'b0, 8'h11); add_beat(0, 1'b0, 1'b1, 8'h22);
    build_exp(); run(50);
    check("t1_first_out_cycle", 32'(first_out), 32'd2);
    check("t1_err", 32'(err_cnt), 32'd0);

    // Tie from reset, twice: ch0 then ch1, one bubble between packets.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) add_beat(0, i == 0, i == 2, 8'(8'h01 + i));
      for (int i = 0; i < 3; i++) add_beat(1, i == 0, i == 2, 8'(8'h81 + i));
      build_exp(); run(60);
      check("t2_last_out_cycle", 32'(last_out), 32'd8);
    end

    // Backpressure mid-packet.
    do_reset();
    rdy_mode = 2; stall_lo = 3; stall_hi = 6;
    for (int i = 0; i < 6; i++) add_beat(0, i == 0, i == 5, 8'(8'h40 + i));
    build_exp(); run(60);
    rdy_mode = 0;

    // Single-beat packets alternate.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      add_beat(0, 1'b1, 1'b1, 8'hA5);
      add_beat(1, 1'b1, 1'b1, 8'h5A);
    end
    build_exp(); run(60);
    check("t4_last_out_cycle", 32'(last_out), 32'd12);

    // Orphan beats in IDLE.
    do_reset();
    s0_vld = 1'b1; s0_sop = 1'b0; s0_eop = 1'b0; s0_data = 8'h77; m_rdy = 1'b1;
    #1 check("orphan_rdy", 32'(s0_rdy), 32'd1);
    @(posedge clk); @(negedge clk);
    s0_vld = 1'b0;
    #1;
    check("orphan_m_vld", 32'(m_vld), 32'd0);
    check("orphan_err1", 32'(err_cnt), 32'd1);
    s0_vld = 1'b1; s1_vld = 1'b1; s1_sop = 1'b0; s1_eop = 1'b0; s1_data = 8'h66;
    #1 check("orphan_rdy_both", 32'({s0_rdy, s1_rdy}), 32'd3);
    @(posedge clk); @(negedge clk);
    s0_vld = 1'b0; s1_vld = 1'b0;
    #1;
    check("orphan_err3", 32'(err_cnt), 32'd3);
    check("orphan_m_vld2", 32'(m_vld), 32'd0);
    @(negedge clk);
    add_beat(0, 1'b1, 1'b0, 8'hAA); add_beat(0, 1'b0, 1'b0, 8'h11); add_beat(0, 1'b0, 1'b1, 8'h22);
    build_exp(); run(50);
    check("orphan_err_after_pkt", 32'(err_cnt), 32'd3);

    // Repeated sop inside a grant: forwarded, counted once.
    add_beat(1, 1'b1, 1'b0, 8'h10); add_beat(1, 1'b1, 1'b0, 8'h20); add_beat(1, 1'b0, 1'b1, 8'h30);
    build_exp(); run(50);
    check("seq_err", 32'(err_cnt), 32'd4);

    // Reset after 2 of 4 beats accepted.
    for (int i = 0; i < 4; i++) add_beat(0, i == 0, i == 3, 8'(8'hC0 + i));
    build_exp();
    start_run();
    while (ptr0 < 2 && cyc < 30) cycle();
    check("midrst_progress", 32'(ptr0), 32'd2);
    rst_n = 1'b0;
    {s0_vld, s0_sop, s0_eop} = 3'd0;
    #1;
    check("midrst_m_vld", 32'(m_vld), 32'd0);
    check("midrst_err", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = 1'b1; pc0 = 0; pc1 = 0; hold_prev = 1'b0;
    q0.delete(); q1.delete(); expq.delete();
    for (int i = 0; i < 3; i++) add_beat(1, i == 0, i == 2, 8'(8'hD0 + i));
    build_exp(); run(50);
    for (int i = 0; i < 2; i++) add_beat(1, i == 0, i == 1, 8'(8'hE0 + i));
    for (int i = 0; i < 2; i++) add_beat(0, i == 0, i == 1, 8'(8'hF0 + i));
    build_exp(); run(50);

    // Randomized traffic with gaps and random backpressure.
    do_reset();
    rdy_mode = 1; gap_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      int n0, n1;
      n0 = int'($urandom_range(2, 8));
      n1 = int'($urandom_range(2, 8));
      for (int p = 0; p < n0; p++) add_pkt(0, int'($urandom_range(1, 5)));
      for (int p = 0; p < n1; p++) add_pkt(1, int'($urandom_range(1, 5)));
      build_exp(); run(3000);
    end
    check("rand_err", 32'(err_cnt), 32'd0);
`ifdef PKT_RR_ARB_STAT_EN
    check("pkt_cnt0", 32'(pkt_cnt0), 32'(pc0));
    check("pkt_cnt1", 32'(pkt_cnt1), 32'(pc1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
